// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a one-entry
// holding register with valid/ready handshake plus sticky framing/overrun flags.
module uart_rx #(
  parameter int CPB = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       status_err,
  output logic       status_ovr,
  input  logic       status_clr
);

  localparam int CW = $clog2(CPB);
  // The counter is loaded with N-1 and the sample fires when it reaches 0,
  // so a load of CPB/2-1 on edge cycle T lands the first sample on T+CPB/2.
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CPB - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t          state, nxt;
  logic            sync0, line, line_d;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            tick;
  logic            load_half, reload, shift_en, load_byte, err_set;
  logic            xfer, ovr_set;

  assign tick = (cnt == '0);
  assign xfer = rx_valid & rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0  <= 1'b1;
      line   <= 1'b1;
      line_d <= 1'b1;
    end else begin
      sync0  <= uart_rxd;
      line   <= sync0;
      line_d <= line;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (line_d && !line)        nxt = START;
      START:   if (tick)                   nxt = line ? IDLE : DATA;
      DATA:    if (tick && bit_idx == 3'd7) nxt = STOP;
      STOP:    if (tick)                   nxt = line ? IDLE : BREAK;
      BREAK:   if (line)                   nxt = IDLE;
      default:                             nxt = IDLE;
    endcase
  end

  always_comb begin
    load_half = 1'b0;
    reload    = 1'b0;
    shift_en  = 1'b0;
    load_byte = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE:  load_half = line_d & ~line;
      START: reload    = tick & ~line;
      DATA: begin
        reload   = tick;
        shift_en = tick;
      end
      STOP: begin
        load_byte = tick & line;
        err_set   = tick & ~line;
      end
      default: ;
    endcase
  end

  // Counter never wraps: it parks at 0 once a frame ends or a start is rejected.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else begin
      if (load_half)       cnt <= HALF_M1;
      else if (reload)     cnt <= BIT_M1;
      else if (cnt != '0)  cnt <= cnt - 1'b1;

      if (load_half)       bit_idx <= 3'd0;
      else if (shift_en)   bit_idx <= bit_idx + 3'd1;

      if (shift_en)        shift <= {line, shift[7:1]};
    end
  end

  assign ovr_set = load_byte & rx_valid & ~rx_ready;

  // A load coinciding with a transfer refills the register without dropping valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      status_err <= 1'b0;
      status_ovr <= 1'b0;
    end else begin
      if (load_byte && (!rx_valid || xfer)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (xfer) begin
        rx_valid <= 1'b0;
      end

      if (err_set)         status_err <= 1'b1;
      else if (status_clr) status_err <= 1'b0;

      if (ovr_set)         status_ovr <= 1'b1;
      else if (status_clr) status_ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames plus hand-written overrun, break, reset
// and latency sequences on CPB=16, with latency checks on CPB=4 and CPB=2500.
`timescale 1ns/1ps
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rxd16, rxd4, rxd2500, rdy16, clr16;
  logic [7:0] d16, d4, d2500;
  logic       v16, v4, v2500, e16, o16, e4, o4, e2500, o2500;

  uart_rx #(.CPB(16)) u16 (
    .clk(clk), .rst(rst), .uart_rxd(rxd16), .rx_data(d16), .rx_valid(v16),
    .rx_ready(rdy16), .status_err(e16), .status_ovr(o16), .status_clr(clr16));
  uart_rx #(.CPB(4)) u4 (
    .clk(clk), .rst(rst), .uart_rxd(rxd4), .rx_data(d4), .rx_valid(v4),
    .rx_ready(1'b1), .status_err(e4), .status_ovr(o4), .status_clr(1'b0));
  uart_rx #(.CPB(2500)) u2500 (
    .clk(clk), .rst(rst), .uart_rxd(rxd2500), .rx_data(d2500), .rx_valid(v2500),
    .rx_ready(1'b1), .status_err(e2500), .status_ovr(o2500), .status_clr(1'b0));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: log transferred bytes, the cycle of each valid rise, and valid-high cycles.
  logic [7:0] got16[$], got4[$], got2500[$];
  int   rise16 = 0, rise4 = 0, rise2500 = 0;
  int   vhi16 = 0, vhi4 = 0, vhi2500 = 0;
  logic v16_q = 1'b0, v4_q = 1'b0, v2500_q = 1'b0;

  always @(negedge clk) begin
    if (v16 && rdy16) got16.push_back(d16);
    if (v16 && !v16_q) rise16 <= cyc;
    vhi16 <= vhi16 + int'(v16);
    v16_q <= v16;
  end
  always @(negedge clk) begin
    if (v4) got4.push_back(d4);
    if (v4 && !v4_q) rise4 <= cyc;
    vhi4 <= vhi4 + int'(v4);
    v4_q <= v4;
  end
  always @(negedge clk) begin
    if (v2500) got2500.push_back(d2500);
    if (v2500 && !v2500_q) rise2500 <= cyc;
    vhi2500 <= vhi2500 + int'(v2500);
    v2500_q <= v2500;
  end

  int errors = 0;
  int checks = 0;
  logic [7:0] exp16[$];
  int rd16 = 0;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         exp_err;
  } vec_t;
  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input int which, input logic v);
    case (which)
      0:       rxd16   = v;
      1:       rxd4    = v;
      default: rxd2500 = v;
    endcase
  endtask

  // Start bit, 8 data bits LSB first, stop bit; the line is left at the stop level.
  task automatic send(input int which, input int cpb, input logic [7:0] d,
                      input bit stop_ok, output int c0);
    c0 = cyc;
    drv(which, 1'b0);
    repeat (cpb) tick();
    for (int i = 0; i < 8; i++) begin
      drv(which, d[i]);
      repeat (cpb) tick();
    end
    drv(which, stop_ok);
    repeat (cpb) tick();
  endtask

  task automatic sb_check(input string nm);
    check({nm, " count"}, 32'(got16.size() - rd16), 32'(exp16.size()));
    while (exp16.size() > 0) begin
      logic [7:0] e;
      e = exp16.pop_front();
      if (rd16 < got16.size()) begin
        check({nm, " byte"}, 32'(got16[rd16]), 32'(e));
        rd16++;
      end
    end
    rd16 = got16.size();
  endtask

  task automatic pulse_clr();
    clr16 = 1'b1;
    tick();
    clr16 = 1'b0;
    tick();
  endtask

  int c0, c1, h;

  initial begin
    rst = 1'b1; rxd16 = 1'b1; rxd4 = 1'b1; rxd2500 = 1'b1; rdy16 = 1'b0; clr16 = 1'b0;
    tbl[0] = '{8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'hFF, 1'b1, 1'b0};
    tbl[2] = '{8'h3C, 1'b1, 1'b0};
    tbl[3] = '{8'hC3, 1'b0, 1'b1};
    tbl[4] = '{8'h81, 1'b1, 1'b0};
    tbl[5] = '{8'h7E, 1'b0, 1'b1};

    repeat (3) tick();
    check("reset data", 32'(d16), 32'h0);
    check("reset valid", 32'(v16), 32'h0);
    check("reset err", 32'(e16), 32'h0);
    check("reset ovr", 32'(o16), 32'h0);
    rst = 1'b0;
    repeat (4) tick();

    // Basic frame and exact latency
    rdy16 = 1'b1;
    h = vhi16;
    exp16.push_back(8'hA5);
    send(0, 16, 8'hA5, 1'b1, c0);
    repeat (32) tick();
    check("latency16", rise16 - c0, 155);
    check("pulse16", vhi16 - h, 1);
    sb_check("A5");
    check("A5 err", 32'(e16), 32'h0);
    check("A5 ovr", 32'(o16), 32'h0);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].stop_ok) exp16.push_back(tbl[i].data);
      send(0, 16, tbl[i].data, tbl[i].stop_ok, c0);
      rxd16 = 1'b1;
      repeat (40) tick();
      sb_check($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d err", i), 32'(e16), 32'(tbl[i].exp_err));
      pulse_clr();
      check($sformatf("tbl%0d clr", i), 32'(e16), 32'h0);
    end

    // Short glitch is a false start; a frame right after must still be received
    h = vhi16;
    rxd16 = 1'b0;
    repeat (3) tick();
    rxd16 = 1'b1;
    repeat (8) tick();
    exp16.push_back(8'h96);
    send(0, 16, 8'h96, 1'b1, c0);
    repeat (40) tick();
    check("glitch pulses", vhi16 - h, 1);
    check("glitch err", 32'(e16), 32'h0);
    sb_check("after glitch");

    // Framing error followed by a held-low break
    h = vhi16;
    send(0, 16, 8'h00, 1'b0, c0);
    repeat (40) tick();
    rxd16 = 1'b1;
    repeat (20) tick();
    check("break err", 32'(e16), 32'h1);
    check("break no valid", vhi16 - h, 0);
    exp16.push_back(8'h3C);
    send(0, 16, 8'h3C, 1'b1, c0);
    repeat (40) tick();
    sb_check("after break");
    check("err sticky", 32'(e16), 32'h1);
    pulse_clr();
    check("err cleared", 32'(e16), 32'h0);

    // Overrun: second byte dropped while the first is held
    rdy16 = 1'b0;
    send(0, 16, 8'h11, 1'b1, c0);
    send(0, 16, 8'h22, 1'b1, c0);
    repeat (40) tick();
    check("ovr data", 32'(d16), 32'h11);
    check("ovr valid", 32'(v16), 32'h1);
    check("ovr flag", 32'(o16), 32'h1);
    exp16.push_back(8'h11);
    rdy16 = 1'b1;
    repeat (3) tick();
    check("ovr drained", 32'(v16), 32'h0);
    sb_check("ovr");
    pulse_clr();
    check("ovr cleared", 32'(o16), 32'h0);

    // Transfer on the exact load cycle of the next byte
    rdy16 = 1'b0;
    exp16.push_back(8'h11);
    send(0, 16, 8'h11, 1'b1, c0);
    fork
      send(0, 16, 8'h22, 1'b1, c1);
      begin
        repeat (154) tick();
        rdy16 = 1'b1;
        tick();
        rdy16 = 1'b0;
      end
    join
    check("same-cycle data", 32'(d16), 32'h22);
    check("same-cycle valid", 32'(v16), 32'h1);
    check("same-cycle ovr", 32'(o16), 32'h0);
    exp16.push_back(8'h22);
    rdy16 = 1'b1;
    repeat (3) tick();
    check("same-cycle drained", 32'(v16), 32'h0);
    sb_check("same-cycle");

    // Reset in the middle of data bit 4
    h = vhi16;
    fork
      send(0, 16, 8'h5A, 1'b1, c1);
      begin
        repeat (88) tick();
        rst = 1'b1;
        repeat (3) tick();
        check("midrst data", 32'(d16), 32'h0);
        check("midrst valid", 32'(v16), 32'h0);
        check("midrst err", 32'(e16), 32'h0);
        check("midrst ovr", 32'(o16), 32'h0);
        repeat (77) tick();
        rst = 1'b0;
      end
    join
    repeat (40) tick();
    check("midrst no valid", vhi16 - h, 0);
    sb_check("midrst");
    exp16.push_back(8'h81);
    send(0, 16, 8'h81, 1'b1, c0);
    repeat (40) tick();
    sb_check("after midrst");

    // Same latency check at the parameter extremes
    h = vhi4;
    send(1, 4, 8'hA5, 1'b1, c0);
    repeat (20) tick();
    check("latency4", rise4 - c0, 41);
    check("pulse4", vhi4 - h, 1);
    check("count4", 32'(got4.size()), 32'h1);
    if (got4.size() > 0) check("data4", 32'(got4[got4.size()-1]), 32'hA5);
    check("flags4", {30'h0, e4, o4}, 32'h0);

    h = vhi2500;
    send(2, 2500, 8'hA5, 1'b1, c0);
    repeat (3000) tick();
    check("latency2500", rise2500 - c0, 23753);
    check("pulse2500", vhi2500 - h, 1);
    check("count2500", 32'(got2500.size()), 32'h1);
    if (got2500.size() > 0) check("data2500", 32'(got2500[got2500.size()-1]), 32'hA5);
    check("flags2500", {30'h0, e2500, o2500}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CPB, default 2500, clock cycles per UART bit (24 MHz / 9600 baud); legal range 4..65535.
REQ-002 SHALL have port: clk  input  1  system clock; the only clock, all logic on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: uart_rxd  input  1  asynchronous serial line; idle high; 8N1 frames, LSB first.
REQ-005 SHALL have port: rx_data  output  8  received byte from the holding register.
REQ-006 SHALL have port: rx_valid  output  1  holding register full.
REQ-007 SHALL have port: rx_ready  input  1  consumer accepts rx_data.
REQ-008 SHALL have port: status_err  output  1  sticky framing-error flag.
REQ-009 SHALL have port: status_ovr  output  1  sticky overrun flag.
REQ-010 SHALL have port: status_clr  input  1  one-cycle pulse that clears both sticky flags.

Function
REQ-011 SHALL pass uart_rxd through a 2-flop synchronizer; the synchronizer output is "line" below, so line lags uart_rxd by 2 cycles.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE: a start edge is the first cycle T on which line=0 after line=1 on the previous cycle; on that edge the FSM SHALL go to START and load the bit counter for CPB/2 cycles (integer floor).
REQ-014 START: line SHALL be sampled at T+CPB/2; line=1 is a false start and SHALL return the FSM to IDLE with no flag change; line=0 SHALL go to DATA.
REQ-015 DATA: bit i (i=0..7) SHALL be sampled at T+CPB/2+(i+1)*CPB and shifted in LSB first; after bit 7 the FSM SHALL go to STOP.
REQ-016 STOP: line SHALL be sampled at T+CPB/2+9*CPB; line=1 loads the byte (REQ-018) and goes to IDLE.
REQ-017 STOP with line=0: the byte SHALL be discarded, status_err SHALL be set, and the FSM SHALL go to BREAK; BREAK SHALL return to IDLE on the first cycle line=1, without detecting a start edge on that cycle.
REQ-018 Load: rx_data and rx_valid SHALL update on the cycle after the stop sample (latency 1 cycle).
REQ-019 Handshake: a transfer occurs on any cycle with rx_valid=1 and rx_ready=1; rx_valid SHALL be 0 on the next cycle unless a load occurs on that same edge.
REQ-020 rx_data SHALL be stable while rx_valid=1 and no transfer has occurred.
REQ-021 Load while rx_valid=1 with no transfer on the same cycle: the new byte SHALL be discarded, the old byte kept, and status_ovr set.
REQ-022 Load and transfer on the same cycle: the new byte SHALL be loaded, rx_valid SHALL stay 1, and status_ovr SHALL be unchanged.
REQ-023 Sticky flags SHALL stay set until status_clr or rst; if status_clr coincides with a new set event, the set event SHALL win.
REQ-024 The bit counter SHALL be wide enough for CPB-1, SHALL count down to 0, SHALL reload CPB-1 after each sample, and SHALL NOT wrap.
REQ-025 Receiving SHALL continue regardless of rx_valid; back-to-back frames with one stop bit SHALL be received without loss when each byte is accepted before the next load.

Reset
REQ-026 On rst=1 at a clock edge: FSM=IDLE, counters=0, shift register=0, rx_data=8'h00, rx_valid=0, status_err=0, status_ovr=0, both synchronizer flops=1.
REQ-027 Reset mid-frame SHALL abort the frame; the next byte SHALL be received only after a new start edge.
REQ-028 While rst=1, rx_ready and status_clr SHALL be ignored.

Verification (CPB=16 unless stated)
REQ-029 Send 0xA5 with valid stop, rx_ready=1 -> rx_valid=1 for exactly 1 cycle, 2+8+9*16+1 cycles after uart_rxd falls; rx_data=0xA5; both flags 0.
REQ-030 Low glitch of 3 cycles on idle line -> no rx_valid, flags 0, FSM back in IDLE at T+8.
REQ-031 Send 0x00 with stop bit 0, then hold line low 40 cycles, then release -> status_err=1, rx_valid=0; then send 0x3C -> rx_data=0x3C; status_clr pulse -> status_err=0.
REQ-032 Send 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_data=0x11, status_ovr=1; assert rx_ready -> one transfer of 0x11, then rx_valid=0.
REQ-033 Raise rx_ready exactly on the cycle 0x22 loads with 0x11 pending -> 0x11 transferred, rx_data=0x22, rx_valid=1, status_ovr=0.
REQ-034 Assert rst during data bit 4 of 0x5A -> all outputs at reset values; the partial byte is never presented; next frame 0x81 -> rx_data=0x81; repeat REQ-029 with CPB=4 and CPB=2500.
